// File: rtl/aes_pkg.sv
// Shared AES-128 constants, S-boxes, GF(2^8) helpers and state-transform functions.
package aes_pkg;

    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned RND_W   = 4;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_EXPAND, S_INIT_ARK, S_ROUND, S_FINAL, S_DONE
    } dec_state_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant; InvMixColumns only needs 9, 11, 13 and 14.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rcon(input logic [RND_W-1:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] sub_rot_word(input logic [WORD_W-1:0] w);
        return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
    endfunction

    // Byte n of the block lives at [127-8n -: 8]; column c is bytes 4c..4c+3.
    function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_sub_bytes(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
        return o;
    endfunction

    function automatic logic [BLOCK_W-1:0] inv_mix_columns(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {
                gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9),
                gmul(a0, 4'd9)  ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13),
                gmul(a0, 4'd13) ^ gmul(a1, 4'd9)  ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11),
                gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9)  ^ gmul(a3, 4'd14)};
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of AES-128 key expansion: K(r-1)->Kr forward, Kr->K(r-1) inverse.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] rk,
    input  logic [RND_W-1:0]   round,
    input  logic               inv,
    output logic [BLOCK_W-1:0] rk_next_c
);

    logic [WORD_W-1:0] w0, w1, w2, w3;
    logic [WORD_W-1:0] n0, n1, n2, n3;
    logic [WORD_W-1:0] rc;

    always_comb begin
        {w0, w1, w2, w3} = rk;
        rc = {rcon(round), 24'h000000};
        n0 = '0;
        n1 = '0;
        n2 = '0;
        n3 = '0;
        if (!inv) begin
            n0 = w0 ^ sub_rot_word(w3) ^ rc;
            n1 = w1 ^ n0;
            n2 = w2 ^ n1;
            n3 = w3 ^ n2;
        end else begin
            n3 = w3 ^ w2;
            n2 = w2 ^ w1;
            n1 = w1 ^ w0;
            n0 = w0 ^ sub_rot_word(n3) ^ rc;
        end
        rk_next_c = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes128_decryption_block.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys derived on the fly.
module aes128_decryption_block
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               n_rst,
    input  logic               decryptEnable,
    input  logic [BLOCK_W-1:0] key,
    input  logic [BLOCK_W-1:0] inputData,
    output logic [BLOCK_W-1:0] outputData
);

    dec_state_e         fsm_q, fsm_d;
    logic [RND_W-1:0]   rnd_q;
    logic [BLOCK_W-1:0] st_q, key_q;
    logic [BLOCK_W-1:0] key_next_c, ark_c;

    // Expansion walks forward to K10; every later phase walks back one key per cycle.
    aes_key_step u_key_step (
        .rk        (key_q),
        .round     (rnd_q),
        .inv       (fsm_q != S_EXPAND),
        .rk_next_c (key_next_c)
    );

    assign ark_c = inv_sub_bytes(inv_shift_rows(st_q)) ^ key_q;

    always_ff @(posedge clk) begin
        if (!n_rst) fsm_q <= S_IDLE;
        else        fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE:     if (decryptEnable) fsm_d = S_LOAD;
            S_LOAD:     fsm_d = S_EXPAND;
            S_EXPAND:   if (rnd_q == 4'd10) fsm_d = S_INIT_ARK;
            S_INIT_ARK: fsm_d = S_ROUND;
            S_ROUND:    if (rnd_q == 4'd1) fsm_d = S_FINAL;
            S_FINAL:    fsm_d = S_DONE;
            S_DONE:     if (!decryptEnable) fsm_d = S_IDLE;
            default:    fsm_d = S_IDLE;
        endcase
    end

    // rnd_q holds at 10 leaving EXPAND so INIT_ARK can invert with Rcon(10).
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rnd_q      <= '0;
            st_q       <= '0;
            key_q      <= '0;
            outputData <= '0;
        end else begin
            case (fsm_q)
                S_LOAD: begin
                    st_q  <= inputData;
                    key_q <= key;
                    rnd_q <= 4'd1;
                end
                S_EXPAND: begin
                    key_q <= key_next_c;
                    if (rnd_q != 4'd10) rnd_q <= rnd_q + 4'd1;
                end
                S_INIT_ARK: begin
                    st_q  <= st_q ^ key_q;
                    key_q <= key_next_c;
                    rnd_q <= rnd_q - 4'd1;
                end
                S_ROUND: begin
                    st_q  <= inv_mix_columns(ark_c);
                    key_q <= key_next_c;
                    rnd_q <= rnd_q - 4'd1;
                end
                S_FINAL: outputData <= ark_c;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_decryption_block.sv
// Directed-vector bench for the iterative AES-128 decryption block.
module tb_aes128_decryption_block;

    logic         tb_clk;
    logic         n_rst;
    logic         decryptEnable;
    logic [127:0] key;
    logic [127:0] inputData;
    logic [127:0] outputData;

    int n_assert;
    int n_fail;

    localparam logic [127:0] KA = 128'h33DE20E331BA5A525AB7C2495A767B5A;
    localparam logic [127:0] CA = 128'h67928dd5470d4a11f0ea4ae7d49b2dd4;
    localparam logic [127:0] PA = 128'hE6FEBF30133874EBCB49226CD36D0D4F;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;

    aes128_decryption_block dut (
        .clk           (tb_clk),
        .n_rst         (n_rst),
        .decryptEnable (decryptEnable),
        .key           (key),
        .inputData     (inputData),
        .outputData    (outputData)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic tick(input int n);
        repeat (n) @(posedge tb_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        n_rst         = 1'b0;
        decryptEnable = 1'b0;
        key           = KA;
        inputData     = CA;

        // Reset and idle
        tick(1);
        check("reset", outputData, 128'h0);
        n_rst = 1'b1;
        tick(4);
        check("idle_zero", outputData, 128'h0);

        // Vector A: exact 22-cycle latency, then held
        decryptEnable = 1'b1;
        tick(1);
        tick(21);
        check("A_before_E22", outputData, 128'h0);
        tick(1);
        check("A_at_E22", outputData, PA);
        tick(9);
        check("A_hold_E31", outputData, PA);

        // Enable held high in DONE with new inputs: no restart
        key       = K1;
        inputData = C1;
        tick(30);
        check("no_restart", outputData, PA);

        // Drop and re-raise with FIPS-197 C.1
        decryptEnable = 1'b0;
        tick(2);
        decryptEnable = 1'b1;
        tick(1);
        tick(21);
        check("C1_before_E22", outputData, PA);
        tick(1);
        check("C1_at_E22", outputData, P1);

        // Inputs changed at E5 must not disturb the latched operation
        decryptEnable = 1'b0;
        tick(2);
        key           = KA;
        inputData     = CA;
        decryptEnable = 1'b1;
        tick(1);
        tick(4);
        key           = K1;
        inputData     = C1;
        decryptEnable = 1'b0;
        tick(17);
        check("midchg_before_E22", outputData, P1);
        tick(1);
        check("midchg_at_E22", outputData, PA);

        // Reset at E10 aborts; enable held high on that edge too
        tick(2);
        decryptEnable = 1'b1;
        tick(1);
        tick(9);
        n_rst = 1'b0;
        tick(1);
        check("reset_E10", outputData, 128'h0);
        n_rst         = 1'b1;
        decryptEnable = 1'b0;
        tick(20);
        check("aborted_stays_zero", outputData, 128'h0);

        // Fresh operation after the abort
        key           = KA;
        inputData     = CA;
        decryptEnable = 1'b1;
        tick(1);
        tick(21);
        check("after_rst_before_E22", outputData, 128'h0);
        tick(1);
        check("after_rst_at_E22", outputData, PA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
